// File: rtl/muldiv_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_ctrl
// Brief    : Iterative HI/LO multiply/divide sequencer for the EX stage.
//            One bit per cycle: shift-add multiply or restoring divide.
//            The pipeline is stalled until the result is written to HI/LO.
//            MTHI/MTLO writes are also handled here.
// Config   : MULDIV_SIGNED_EN - when defined, MULT/DIV use signed
//            magnitude arithmetic with a sign fix-up. When undefined,
//            MULT/DIV run exactly as MULTU/DIVU.
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_ctrl #(
   parameter int DATA_BUS_WIDTH      = 32,
   parameter int ALU_FUNCT_BUS_WIDTH = 6
) (
   input  logic                           i_clk,
   input  logic                           i_reset,
   input  logic                           i_valid,
   input  logic [ALU_FUNCT_BUS_WIDTH-1:0] i_funct,
   input  logic [DATA_BUS_WIDTH-1:0]      i_op_a,
   input  logic [DATA_BUS_WIDTH-1:0]      i_op_b,
   output logic                           o_stall,
   output logic                           o_done,
   output logic [DATA_BUS_WIDTH-1:0]      o_hi,
   output logic [DATA_BUS_WIDTH-1:0]      o_lo
);

   localparam int W     = DATA_BUS_WIDTH;
   localparam int FW    = ALU_FUNCT_BUS_WIDTH;
   localparam int CNT_W = $clog2(W);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W - 1);

   localparam logic [FW-1:0] FN_MULT  = FW'(6'b011000);
   localparam logic [FW-1:0] FN_MULTU = FW'(6'b011001);
   localparam logic [FW-1:0] FN_DIV   = FW'(6'b011010);
   localparam logic [FW-1:0] FN_DIVU  = FW'(6'b011011);
   localparam logic [FW-1:0] FN_MTHI  = FW'(6'b010001);
   localparam logic [FW-1:0] FN_MTLO  = FW'(6'b010011);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t state;
   state_t state_nxt;

   logic [CNT_W-1:0] cnt;
   logic             op_div;
   logic             div_zero;
   logic [W-1:0]     raw_a;
   logic [W-1:0]     opnd;
   logic [2*W-1:0]   acc;
   logic [2*W-1:0]   acc_nxt;

   logic             is_mul_op;
   logic             is_div_op;
   logic             accept;
   logic             mthi_wr;
   logic             mtlo_wr;
   logic [W-1:0]     a_mag;
   logic [W-1:0]     b_mag;
   logic [W:0]       mul_sum;
   logic [W:0]       div_trial;
   logic [W-1:0]     res_hi;
   logic [W-1:0]     res_lo;

   assign is_mul_op = (i_funct == FN_MULT) || (i_funct == FN_MULTU);
   assign is_div_op = (i_funct == FN_DIV)  || (i_funct == FN_DIVU);

   // Acceptance is forced low while reset is asserted so the stall drops at once.
   assign accept  = i_valid && (state == ST_IDLE) && (is_mul_op || is_div_op) && !i_reset;
   assign mthi_wr = i_valid && (state == ST_IDLE) && (i_funct == FN_MTHI);
   assign mtlo_wr = i_valid && (state == ST_IDLE) && (i_funct == FN_MTLO);

   assign o_stall = accept || (state != ST_IDLE);

`ifdef MULDIV_SIGNED_EN
   logic op_signed;
   logic a_neg;
   logic b_neg;
   logic neg_res;
   logic neg_rem;
   logic [2*W-1:0] prod_neg;

   assign op_signed = (i_funct == FN_MULT) || (i_funct == FN_DIV);
   assign a_neg     = op_signed && i_op_a[W-1];
   assign b_neg     = op_signed && i_op_b[W-1];
   assign a_mag     = a_neg ? -i_op_a : i_op_a;
   assign b_mag     = b_neg ? -i_op_b : i_op_b;
   assign prod_neg  = -acc;

   // Result sign and remainder sign are captured with the operands.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         neg_res <= 1'b0;
         neg_rem <= 1'b0;
      end else if (accept) begin
         neg_res <= a_neg ^ b_neg;
         neg_rem <= a_neg;
      end
   end

   // Sign fix-up of the unsigned magnitude result, then divide-by-zero override.
   always_comb begin
      res_hi = acc[2*W-1:W];
      res_lo = acc[W-1:0];
      if (!op_div) begin
         if (neg_res) begin
            res_hi = prod_neg[2*W-1:W];
            res_lo = prod_neg[W-1:0];
         end
      end else begin
         if (neg_res) res_lo = -acc[W-1:0];
         if (neg_rem) res_hi = -acc[2*W-1:W];
         if (div_zero) begin
            res_lo = {W{1'b1}};
            res_hi = raw_a;
         end
      end
   end
`else
   assign a_mag = i_op_a;
   assign b_mag = i_op_b;

   // Raw unsigned result, with the divide-by-zero override.
   always_comb begin
      res_hi = acc[2*W-1:W];
      res_lo = acc[W-1:0];
      if (op_div && div_zero) begin
         res_lo = {W{1'b1}};
         res_hi = raw_a;
      end
   end
`endif

   // One iteration: shift-add multiply step or restoring divide step.
   always_comb begin
      mul_sum   = {1'b0, acc[2*W-1:W]} + {1'b0, opnd};
      div_trial = acc[2*W-1:W-1] - {1'b0, opnd};
      acc_nxt   = acc;
      if (op_div) begin
         if (!div_trial[W]) acc_nxt = {div_trial[W-1:0], acc[W-2:0], 1'b1};
         else               acc_nxt = {acc[2*W-2:0], 1'b0};
      end else begin
         if (acc[0]) acc_nxt = {mul_sum, acc[W-1:1]};
         else        acc_nxt = {1'b0, acc[2*W-1:1]};
      end
   end

   // Next-state logic: IDLE -> RUN on accept, RUN for W cycles, one DONE cycle.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (accept) state_nxt = ST_RUN;
         ST_RUN:  if (cnt == CNT_LAST) state_nxt = ST_DONE;
         ST_DONE: state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) state <= ST_IDLE;
      else         state <= state_nxt;
   end

   // Operand capture on accept, then one iteration per RUN cycle.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         cnt      <= '0;
         op_div   <= 1'b0;
         div_zero <= 1'b0;
         raw_a    <= '0;
         opnd     <= '0;
         acc      <= '0;
      end else if (accept) begin
         cnt      <= '0;
         op_div   <= is_div_op;
         div_zero <= (i_op_b == '0);
         raw_a    <= i_op_a;
         opnd     <= is_div_op ? b_mag : a_mag;
         acc      <= {{W{1'b0}}, (is_div_op ? a_mag : b_mag)};
      end else if (state == ST_RUN) begin
         cnt      <= cnt + CNT_W'(1);
         acc      <= acc_nxt;
      end
   end

   // HI/LO write on leaving DONE, or direct MTHI/MTLO writes while idle.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         o_hi   <= '0;
         o_lo   <= '0;
         o_done <= 1'b0;
      end else begin
         o_done <= (state == ST_DONE);
         if (state == ST_DONE) begin
            o_hi <= res_hi;
            o_lo <= res_lo;
         end else begin
            if (mthi_wr) o_hi <= i_op_a;
            if (mtlo_wr) o_lo <= i_op_a;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_muldiv_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_muldiv_ctrl
// Brief    : Self-checking bench for muldiv_ctrl. A cycle-level behavioural
//            model (plain 64-bit arithmetic plus a busy countdown) is compared
//            against the DUT outputs every cycle. Directed cases pin
//            known results; random operations cover the rest. The expected
//            values follow MULDIV_SIGNED_EN when it is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_muldiv_ctrl;

   localparam logic [5:0] F_MULT  = 6'b011000;
   localparam logic [5:0] F_MULTU = 6'b011001;
   localparam logic [5:0] F_DIV   = 6'b011010;
   localparam logic [5:0] F_DIVU  = 6'b011011;
   localparam logic [5:0] F_MTHI  = 6'b010001;
   localparam logic [5:0] F_MTLO  = 6'b010011;

`ifdef MULDIV_SIGNED_EN
   localparam logic [31:0] E_M7_HI  = 32'hFFFFFFFF;
   localparam logic [31:0] E_M7_LO  = 32'hFFFFFFEB;
   localparam logic [31:0] E_D7_HI  = 32'hFFFFFFFF;
   localparam logic [31:0] E_D7_LO  = 32'hFFFFFFFD;
   localparam logic [31:0] E_OV_HI  = 32'h00000000;
   localparam logic [31:0] E_OV_LO  = 32'h80000000;
   localparam logic [31:0] E_M2_HI  = 32'hFFFFFFFF;
   localparam logic [31:0] E_M2_LO  = 32'hFFFFFFFE;
`else
   localparam logic [31:0] E_M7_HI  = 32'h00000002;
   localparam logic [31:0] E_M7_LO  = 32'hFFFFFFEB;
   localparam logic [31:0] E_D7_HI  = 32'h00000001;
   localparam logic [31:0] E_D7_LO  = 32'h7FFFFFFC;
   localparam logic [31:0] E_OV_HI  = 32'h80000000;
   localparam logic [31:0] E_OV_LO  = 32'h00000000;
   localparam logic [31:0] E_M2_HI  = 32'h00000001;
   localparam logic [31:0] E_M2_LO  = 32'hFFFFFFFE;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        valid;
   logic [5:0]  funct;
   logic [31:0] a;
   logic [31:0] b;
   logic        stall;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;

   int          checks   = 0;
   int          failures = 0;
   bit          run_cmp  = 1'b0;

   // model state
   int          busy     = 0;
   logic [31:0] m_hi     = '0;
   logic [31:0] m_lo     = '0;
   logic        m_done   = 1'b0;
   logic [31:0] p_hi     = '0;
   logic [31:0] p_lo     = '0;

   // samples taken by tick() at the negative edge
   logic        s_stall;
   logic        s_done;

   muldiv_ctrl #(
      .DATA_BUS_WIDTH      (32),
      .ALU_FUNCT_BUS_WIDTH (6)
   ) dut (
      .i_clk   (clk),
      .i_reset (rst),
      .i_valid (valid),
      .i_funct (funct),
      .i_op_a  (a),
      .i_op_b  (b),
      .o_stall (stall),
      .o_done  (done),
      .o_hi    (hi),
      .o_lo    (lo)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
      end
   endtask

   function automatic bit is_md(input logic [5:0] f);
      return (f == F_MULT) || (f == F_MULTU) || (f == F_DIV) || (f == F_DIVU);
   endfunction

   // Architectural result of one mult/div using plain 64-bit arithmetic.
   function automatic void compute(input logic [5:0] f, input logic [31:0] x, input logic [31:0] y,
                                   output logic [31:0] h, output logic [31:0] l);
      longint     sx;
      longint     sy;
      longint     q;
      longint     r;
      logic [63:0] p;
      bit         sgn;
      sgn = 1'b0;
`ifdef MULDIV_SIGNED_EN
      sgn = (f == F_MULT) || (f == F_DIV);
`endif
      sx = sgn ? longint'($signed(x)) : longint'({32'b0, x});
      sy = sgn ? longint'($signed(y)) : longint'({32'b0, y});
      if ((f == F_MULT) || (f == F_MULTU)) begin
         p = 64'(sx * sy);
         h = p[63:32];
         l = p[31:0];
      end else if (y == 32'd0) begin
         l = 32'hFFFFFFFF;
         h = x;
      end else begin
         q = sx / sy;
         r = sx % sy;
         l = q[31:0];
         h = r[31:0];
      end
   endfunction

   // Advance the model across one rising edge using the inputs held before it.
   task automatic model_update();
      if (busy != 0) begin
         busy--;
         m_done = 1'b0;
         if (busy == 0) begin
            m_hi   = p_hi;
            m_lo   = p_lo;
            m_done = 1'b1;
         end
      end else begin
         m_done = 1'b0;
         if (valid) begin
            if (is_md(funct)) begin
               compute(funct, a, b, p_hi, p_lo);
               busy = 33;
            end else if (funct == F_MTHI) begin
               m_hi = a;
            end else if (funct == F_MTLO) begin
               m_lo = a;
            end
         end
      end
   endtask

   // One clock: sample at the falling edge, update the model, land 1 after the rising edge.
   task automatic tick();
      @(negedge clk);
      s_stall = stall;
      s_done  = done;
      #2;
      if (!rst) model_update();
      @(posedge clk);
      #1;
   endtask

   // While the model says the unit is busy, throw random inputs at it.
   task automatic drive_filler();
      if (busy != 0) begin
         valid = 1'($urandom_range(0, 1));
         funct = 6'($urandom);
         a     = $urandom;
         b     = $urandom;
      end else begin
         valid = 1'b0;
      end
   endtask

   task automatic do_op(input logic [5:0] f, input logic [31:0] x, input logic [31:0] y,
                        output int ncyc);
      bit got;
      valid = 1'b1;
      funct = f;
      a     = x;
      b     = y;
      ncyc  = 0;
      got   = 1'b0;
      for (int i = 0; i < 60; i++) begin
         tick();
         if (s_stall) ncyc++;
         if (s_done) begin
            got = 1'b1;
            break;
         end
         drive_filler();
      end
      valid = 1'b0;
      if (!got) chk("op_timeout", 32'd0, 32'd1);
   endtask

   logic [31:0] pick_vals [6] = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'h2};

   function automatic logic [31:0] pick();
      if ($urandom_range(0, 2) == 0) return pick_vals[$urandom_range(0, 5)];
      return $urandom;
   endfunction

   // Per-cycle comparison of every output against the model.
   initial begin
      forever begin
         @(negedge clk);
         if (!rst && run_cmp) begin
            chk("stall", {31'b0, stall}, {31'b0, (busy != 0) || (valid && is_md(funct))});
            chk("done",  {31'b0, done},  {31'b0, m_done});
            chk("hi",    hi,             m_hi);
            chk("lo",    lo,             m_lo);
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int          n;
      int          r;
      logic [5:0]  md_tab [4] = '{F_MULT, F_MULTU, F_DIV, F_DIVU};
      logic [5:0]  f;

      rst   = 1'b1;
      valid = 1'b0;
      funct = '0;
      a     = '0;
      b     = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_stall", {31'b0, stall}, 32'd0);
      chk("rst_done",  {31'b0, done},  32'd0);
      chk("rst_hi",    hi,             32'd0);
      chk("rst_lo",    lo,             32'd0);
      rst     = 1'b0;
      run_cmp = 1'b1;
      tick();

      // MULTU max x max, with stall length
      do_op(F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, n);
      chk("multu_cycles", n,    32'd34);
      chk("multu_hi",     hi,   32'hFFFFFFFE);
      chk("multu_lo",     lo,   32'h00000001);
      chk("model_multu_hi", m_hi, 32'hFFFFFFFE);

      do_op(F_MULT, 32'hFFFFFFF9, 32'd3, n);
      chk("mult7_hi", hi, E_M7_HI);
      chk("mult7_lo", lo, E_M7_LO);
      chk("model_mult7_hi", m_hi, E_M7_HI);

      do_op(F_DIVU, 32'd100, 32'd7, n);
      chk("divu_lo", lo, 32'd14);
      chk("divu_hi", hi, 32'd2);
      chk("model_divu_lo", m_lo, 32'd14);

      do_op(F_DIV, 32'hFFFFFFF9, 32'd2, n);
      chk("div7_lo", lo, E_D7_LO);
      chk("div7_hi", hi, E_D7_HI);

      do_op(F_DIVU, 32'h1234, 32'd0, n);
      chk("dz_cycles", n,  32'd34);
      chk("dz_lo",     lo, 32'hFFFFFFFF);
      chk("dz_hi",     hi, 32'h00001234);
      chk("model_dz_hi", m_hi, 32'h00001234);

      do_op(F_DIV, 32'h80000000, 32'hFFFFFFFF, n);
      chk("ovf_cycles", n,  32'd34);
      chk("ovf_lo",     lo, E_OV_LO);
      chk("ovf_hi",     hi, E_OV_HI);

      do_op(F_MULT, 32'hFFFFFFFF, 32'd2, n);
      chk("m2_hi", hi, E_M2_HI);
      chk("m2_lo", lo, E_M2_LO);

      // Reset pulse in the middle of an iteration sequence
      valid = 1'b1;
      funct = F_MULTU;
      a     = 32'h12345678;
      b     = 32'h9ABCDEF0;
      tick();
      valid = 1'b0;
      repeat (10) tick();
      rst = 1'b1;
      #1;
      chk("midrst_stall", {31'b0, stall}, 32'd0);
      chk("midrst_done",  {31'b0, done},  32'd0);
      chk("midrst_hi",    hi,             32'd0);
      chk("midrst_lo",    lo,             32'd0);
      busy   = 0;
      m_hi   = '0;
      m_lo   = '0;
      m_done = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;

      valid = 1'b1;
      funct = F_MTHI;
      a     = 32'hA5A5A5A5;
      tick();
      valid = 1'b0;
      chk("mthi_stall", {31'b0, s_stall}, 32'd0);
      chk("mthi_hi",    hi,               32'hA5A5A5A5);
      chk("mthi_done",  {31'b0, done},    32'd0);
      tick();

      // Random mix of mult/div, MTHI/MTLO and unrelated funct codes
      for (int k = 0; k < 30; k++) begin
         r = $urandom_range(0, 9);
         if (r <= 5) begin
            do_op(md_tab[$urandom_range(0, 3)], pick(), pick(), n);
            chk("rand_cycles", n, 32'd34);
         end else begin
            if (r == 6)      f = F_MTHI;
            else if (r == 7) f = F_MTLO;
            else begin
               f = 6'($urandom);
               if (is_md(f)) f = 6'b100000;
            end
            valid = 1'b1;
            funct = f;
            a     = $urandom;
            b     = $urandom;
            tick();
            valid = 1'b0;
            tick();
         end
      end

      repeat (2) tick();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/muldiv_ctrl.md
# muldiv_ctrl

Iterative multiply/divide sequencer for the EX stage, the HI/LO resource alongside the main ALU. It accepts MULT, MULTU, DIV and DIVU when the ALU control code is R-type. It runs a one-bit-per-cycle shift-add multiply or restoring divide and stalls the pipeline until the result lands in HI/LO. It also services MTHI/MTLO writes and exposes HI/LO for MFHI/MFLO forwarding.

## Interface
- DATA_BUS_WIDTH, 32, operand and HI/LO width.
- ALU_FUNCT_BUS_WIDTH, 6, funct field width.
- i_clk  in  1  single clock; all state changes on the rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_valid  in  1  EX-stage instruction is R-type and not bubbled.
- i_funct  in  ALU_FUNCT_BUS_WIDTH  funct field.
- i_op_a  in  DATA_BUS_WIDTH  rs value: multiplicand or dividend; also the MTHI/MTLO source.
- i_op_b  in  DATA_BUS_WIDTH  rt value: multiplier or divisor.
- o_stall  out  1  freeze IF/ID/EX.
- o_done  out  1  one-cycle pulse; HI/LO hold a new mult/div result.
- o_hi  out  DATA_BUS_WIDTH  HI register.
- o_lo  out  DATA_BUS_WIDTH  LO register.

## Operation
- Funct codes:
  - MULT 011000, MULTU 011001, DIV 011010, DIVU 011011.
  - MTHI 010001, MTLO 010011.
  - All other codes are ignored.
- FSM states:
  - IDLE: accepts new operations.
  - RUN: iterations, counted by a 5-bit counter (log2 DATA_BUS_WIDTH).
  - DONE: sign fix-up and HI/LO write.
- Accept condition: `i_valid` high in IDLE with a mult/div funct.
  - Latch the operation kind and the operand magnitudes.
  - For signed ops, take absolute values and record the result sign and remainder sign.
  - Latch a divide-by-zero flag when i_op_b == 0.
  - Clear the counter and go to RUN.
- RUN, multiply:
  - 2×DATA_BUS_WIDTH accumulator.
  - Each cycle: if the multiplier LSB is 1, add the multiplicand into the upper half; then shift the accumulator right one bit, keeping the carry.
- RUN, divide:
  - Restoring division: shift the remainder/quotient pair left one bit, then trial-subtract the divisor.
  - If the result is non-negative, keep it and set the quotient bit to 1.
- RUN exit: after DATA_BUS_WIDTH iterations (counter == 31), go to DONE.
- DONE: apply sign fix-up, then write HI/LO at the exit edge and go to IDLE.
  - Multiply: HI:LO = product; negate the 64-bit product if the result sign is negative.
  - Divide: LO = quotient, negated if the signs of a and b differ; HI = remainder, taking the sign of the dividend.
  - Divide by zero, forced result: LO = all ones, HI = i_op_a as latched.
  - DIV 0x80000000 / 0xFFFFFFFF gives LO = 0x80000000, HI = 0, with no exception.
- MTHI/MTLO:
  - Valid only in IDLE; i_op_a is written to HI or LO at the next edge.
  - No stall, no o_done.
- Any i_valid while not IDLE is ignored; the stall makes this unreachable in normal operation.
- MFHI/MFLO read o_hi/o_lo directly. A read issued behind a mult/div is held by o_stall.

## Timing
- Reset values:
  - State IDLE, counter 0.
  - o_hi = 0, o_lo = 0, o_done = 0, o_stall = 0.
- o_stall = accept OR (state != IDLE).
  - Accept is combinational from i_valid/i_funct and is gated low during reset.
  - The stall rises in the issue cycle T, before the EX/MEM edge.
- Latency, operation accepted in cycle T:
  - T+1..T+32: RUN.
  - T+33: DONE.
  - T+34: new o_hi/o_lo visible, o_done = 1, o_stall = 0.
  - Total stall is 34 cycles.
- Next acceptance: back-to-back operations are possible from T+34.
- o_done is registered and stays high exactly one cycle.
- MTHI/MTLO: o_hi/o_lo update at T+1.
- Reset mid-operation:
  - State, HI/LO, o_done and o_stall clear asynchronously.
  - The partial result is discarded.
- Counter wrap: the counter wraps 31→0 only on the RUN→DONE transition.

## Configuration
- MULDIV_SIGNED_EN defined: MULT/DIV use the signed magnitude-and-fix-up path described above.
- Not defined:
  - Sign-handling logic is removed.
  - MULT executes exactly as MULTU and DIV exactly as DIVU, on the raw bit patterns.
  - Latency is identical.

## Test plan
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF → o_stall high cycles T..T+33; at T+34 HI=0xFFFFFFFE, LO=0x00000001, o_done pulse.
- MULT a=0xFFFFFFF9 (-7), b=3 → HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- DIVU 100/7 → LO=14, HI=2. DIV -7/2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- Divide by zero:
  - DIVU 0x1234/0 → LO=0xFFFFFFFF, HI=0x1234.
  - DIV 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
  - Both keep the 34-cycle stall.
- Reset pulse during RUN iteration 10 → o_stall low immediately and HI=LO=0. Then MTHI 0xA5A5A5A5 → o_hi=0xA5A5A5A5 next cycle, no o_done.
- MULDIV_SIGNED_EN undefined: MULT 0xFFFFFFFF×2 → HI=0x00000001, LO=0xFFFFFFFE.
